dsp_equation_accumulate: RTL

Parametrised accumulate engine for the DSP slave: streams every word of a selected input file through the shared file port, unpacks byte, half-word or word lanes with sign or zero extension, and accumulates into an ACC_W-bit accumulator. It replaces the fixed 32-bit sum equation with a wide accumulator, a sample counter output and a two-word result write. An overflow policy is selectable at build time. It sits beside the other equation engines behind the DSP slave register block and file arbiter.

---
 rtl/dsp_equation_accumulate_if.sv | 38 +++
 rtl/dsp_equation_accumulate.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_equation_accumulate_if.sv
// Bundle of the control registers, result registers and shared file port
// used by the accumulate equation engine. The "master" modport is the engine
// side; the "slave" modport is the register block / file arbiter side.
interface dsp_equation_accumulate_if;
  logic [31:0] dsp_input0_reg;
  logic [31:0] dsp_input1_reg;
  logic [31:0] dsp_input3_reg;
  logic [7:0]  file_num;
  logic        file_read;
  logic        file_write;
  logic [31:0] file_write_data;
  logic [31:0] file_read_data;
  logic        file_active;
  logic [31:0] rd_ptr;
  logic [31:0] wr_ptr;
  logic        equation_done;
  logic        interrupt;
  logic        error;
  logic [31:0] dsp_output0_reg;
  logic [31:0] dsp_output1_reg;
  logic [31:0] dsp_output2_reg;

  modport master (
    input  dsp_input0_reg, dsp_input1_reg, dsp_input3_reg,
    input  file_read_data, file_active, rd_ptr, wr_ptr,
    output file_num, file_read, file_write, file_write_data,
    output equation_done, interrupt, error,
    output dsp_output0_reg, dsp_output1_reg, dsp_output2_reg
  );

  modport slave (
    output dsp_input0_reg, dsp_input1_reg, dsp_input3_reg,
    output file_read_data, file_active, rd_ptr, wr_ptr,
    input  file_num, file_read, file_write, file_write_data,
    input  equation_done, interrupt, error,
    input  dsp_output0_reg, dsp_output1_reg, dsp_output2_reg
  );
endinterface

// File: rtl/dsp_equation_accumulate.sv
// Accumulate equation engine for the DSP slave.
// Streams every word of the selected input file through the shared file
// port, unpacks byte / half-word / word lanes (sign or zero extended) and
// adds them into an ACC_W-bit accumulator. The result is written to the
// output file as two words (low, then extended upper) and presented on the
// three output registers together with the number of lanes accumulated.
// Build option: DSP_EQUATION_ACCUMULATE_SATURATE_EN clamps the accumulator
// on overflow; without it the accumulator wraps. Both set the error flag.
module dsp_equation_accumulate #(
  parameter int ACC_W = 48,
  parameter int DW    = 32
) (
  input logic                     wb_clk,
  input logic                     wb_rst,
  dsp_equation_accumulate_if.master bus
);

  // Two guard bits so a whole word of lanes plus the accumulator never
  // loses its true value before the range check.
  localparam int SW = ACC_W + 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_RWAIT,
    S_ACCUM,
    S_WRITE_LO,
    S_WLO_WAIT,
    S_WRITE_HI,
    S_WHI_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_startPrev;
  logic [1:0]       r_size;
  logic             r_signed;
  logic             r_irqEn;
  logic [7:0]       r_outFile;
  logic [DW-1:0]    r_word;
  logic [ACC_W-1:0] r_acc;
  logic [31:0]      r_count;
  logic [7:0]       r_fileNum;
  logic             r_fileRead;
  logic             r_fileWrite;
  logic [DW-1:0]    r_fileWriteData;
  logic             r_done;
  logic             r_irq;
  logic             r_error;
  logic [DW-1:0]    r_out0;
  logic [DW-1:0]    r_out1;
  logic [DW-1:0]    r_out2;

  logic             w_startEdge;
  logic [SW-1:0]    w_laneSum;
  logic [31:0]      w_lanes;
  logic [SW-1:0]    w_accExt;
  logic [SW-1:0]    w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_accNext;
  logic [63:0]      w_accWide;
  logic [31:0]      w_accUpper;
  logic             w_ptrEqual;
  logic             w_unused;

  assign w_startEdge = bus.dsp_input0_reg[0] & ~r_startPrev;
  assign w_ptrEqual  = (bus.rd_ptr == bus.wr_ptr);
  assign w_accExt    = {{2{r_signed & r_acc[ACC_W-1]}}, r_acc};
  assign w_sum       = w_accExt + w_laneSum;

  // Control bits and file-number bits outside the decoded fields are ignored.
  assign w_unused = ^{bus.dsp_input0_reg[31:5], bus.dsp_input1_reg[31:8],
                      bus.dsp_input3_reg[31:8]};

  function automatic logic [SW-1:0] extLane8(input logic [7:0] v, input logic s);
    return {{(SW-8){s & v[7]}}, v};
  endfunction

  function automatic logic [SW-1:0] extLane16(input logic [15:0] v, input logic s);
    return {{(SW-16){s & v[15]}}, v};
  endfunction

  function automatic logic [SW-1:0] extLane32(input logic [31:0] v, input logic s);
    return {{(SW-32){s & v[31]}}, v};
  endfunction

  // Unpack the captured word into lanes and sum them at guard-bit width.
  always_comb begin
    w_laneSum = '0;
    w_lanes   = 32'd1;
    case (r_size)
      2'd0: begin
        w_lanes = 32'd4;
        for (int i = 0; i < 4; i++) begin
          w_laneSum = w_laneSum + extLane8(r_word[8*i +: 8], r_signed);
        end
      end
      2'd1: begin
        w_lanes = 32'd2;
        for (int i = 0; i < 2; i++) begin
          w_laneSum = w_laneSum + extLane16(r_word[16*i +: 16], r_signed);
        end
      end
      default: begin
        w_lanes   = 32'd1;
        w_laneSum = extLane32(r_word, r_signed);
      end
    endcase
  end

  // Range check of the guarded sum and the overflow policy.
  always_comb begin
    if (r_signed) begin
      w_ovf = ~((&w_sum[SW-1:ACC_W-1]) | ~(|w_sum[SW-1:ACC_W-1]));
    end else begin
      w_ovf = |w_sum[SW-1:ACC_W];
    end
`ifdef DSP_EQUATION_ACCUMULATE_SATURATE_EN
    if (w_ovf) begin
      if (r_signed) begin
        w_accNext = w_sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        w_accNext = {ACC_W{1'b1}};
      end
    end else begin
      w_accNext = w_sum[ACC_W-1:0];
    end
`else
    w_accNext = w_sum[ACC_W-1:0];
`endif
  end

  // Upper result word: accumulator bits above 31, extended to a full word.
  always_comb begin
    w_accWide            = {64{r_signed & r_acc[ACC_W-1]}};
    w_accWide[ACC_W-1:0] = r_acc;
    w_accUpper           = w_accWide[63:32];
  end

  // Main sequencer: start detection, file handshakes, accumulation, results.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state         <= S_IDLE;
      r_startPrev     <= 1'b1;
      r_size          <= '0;
      r_signed        <= 1'b0;
      r_irqEn         <= 1'b0;
      r_outFile       <= '0;
      r_word          <= '0;
      r_acc           <= '0;
      r_count         <= '0;
      r_fileNum       <= '0;
      r_fileRead      <= 1'b0;
      r_fileWrite     <= 1'b0;
      r_fileWriteData <= '0;
      r_done          <= 1'b0;
      r_irq           <= 1'b0;
      r_error         <= 1'b0;
      r_out0          <= '0;
      r_out1          <= '0;
      r_out2          <= '0;
    end else begin
      r_startPrev <= bus.dsp_input0_reg[0];
      r_done      <= 1'b0;
      r_irq       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_fileNum   <= bus.dsp_input1_reg[7:0];
          r_fileRead  <= 1'b0;
          r_fileWrite <= 1'b0;
          if (w_startEdge) begin
            r_size    <= bus.dsp_input0_reg[2:1];
            r_signed  <= bus.dsp_input0_reg[3];
            r_irqEn   <= bus.dsp_input0_reg[4];
            r_outFile <= bus.dsp_input3_reg[7:0];
            r_acc     <= '0;
            r_count   <= '0;
            r_out0    <= '0;
            r_out1    <= '0;
            r_out2    <= '0;
            if (bus.dsp_input0_reg[2:1] == 2'd3) begin
              r_error <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_error <= 1'b0;
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (w_ptrEqual) begin
            r_fileNum       <= r_outFile;
            r_fileWrite     <= 1'b1;
            r_fileWriteData <= r_acc[31:0];
            r_state         <= S_WRITE_LO;
          end else begin
            r_fileRead <= 1'b1;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          if (bus.file_active) begin
            r_fileRead <= 1'b0;
            r_word     <= bus.file_read_data;
            r_state    <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (bus.file_active) begin
            r_word <= bus.file_read_data;
          end else begin
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_acc   <= w_accNext;
          r_count <= r_count + w_lanes;
          if (w_ovf) begin
            r_error <= 1'b1;
          end
          if (!w_ptrEqual) begin
            r_fileRead <= 1'b1;
            r_state    <= S_READ;
          end else begin
            r_fileNum       <= r_outFile;
            r_fileWrite     <= 1'b1;
            r_fileWriteData <= w_accNext[31:0];
            r_state         <= S_WRITE_LO;
          end
        end
        S_WRITE_LO: begin
          if (bus.file_active) begin
            r_fileWrite <= 1'b0;
            r_state     <= S_WLO_WAIT;
          end
        end
        S_WLO_WAIT: begin
          if (!bus.file_active) begin
            r_fileWrite     <= 1'b1;
            r_fileWriteData <= w_accUpper;
            r_state         <= S_WRITE_HI;
          end
        end
        S_WRITE_HI: begin
          if (bus.file_active) begin
            r_fileWrite <= 1'b0;
            r_state     <= S_WHI_WAIT;
          end
        end
        S_WHI_WAIT: begin
          if (!bus.file_active) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_out0  <= r_acc[31:0];
          r_out1  <= w_accUpper;
          r_out2  <= r_count;
          r_done  <= 1'b1;
          r_irq   <= r_irqEn;
          r_state <= S_IDLE;
        end
        default: begin
          r_fileRead  <= 1'b0;
          r_fileWrite <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.file_num        = r_fileNum;
  assign bus.file_read       = r_fileRead;
  assign bus.file_write      = r_fileWrite;
  assign bus.file_write_data = r_fileWriteData;
  assign bus.equation_done   = r_done;
  assign bus.interrupt       = r_irq;
  assign bus.error           = r_error;
  assign bus.dsp_output0_reg = r_out0;
  assign bus.dsp_output1_reg = r_out1;
  assign bus.dsp_output2_reg = r_out2;

endmodule
